// File: rtl/regfile_writeback_arbiter.sv
// MIPS register-file write-port master: arbitrates ALU and MDU results, buffers MDU results
// in a FIFO and tracks outstanding MDU destinations. Optional macro: WB_MDU_BYPASS_EN.
module regfile_writeback_arbiter #(
  parameter int unsigned BIT_DEPTH      = 32,
  parameter int unsigned LOG_PORT_DEPTH = 5,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alu_we,
  input  logic [LOG_PORT_DEPTH-1:0]        alu_addr,
  input  logic [BIT_DEPTH-1:0]             alu_wd,
  input  logic                             mdu_valid,
  output logic                             mdu_ready,
  input  logic [LOG_PORT_DEPTH-1:0]        mdu_addr,
  input  logic [BIT_DEPTH-1:0]             mdu_wd,
  input  logic                             issue_valid,
  input  logic [LOG_PORT_DEPTH-1:0]        issue_addr,
  output logic [(2**LOG_PORT_DEPTH)-1:0]   busy_vec,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             we,
  output logic [LOG_PORT_DEPTH-1:0]        addr3,
  output logic [BIT_DEPTH-1:0]             wd
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned NumRegs = 2**LOG_PORT_DEPTH;

  logic [LOG_PORT_DEPTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [BIT_DEPTH-1:0]      fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]           rd_ptr_q, wr_ptr_q;

  logic                      accept, alu_req, fifo_empty, pop, push, bypass;
  logic [LOG_PORT_DEPTH-1:0] head_addr;
  logic [BIT_DEPTH-1:0]      head_data;
  logic                      we_d;
  logic [LOG_PORT_DEPTH-1:0] addr3_d;
  logic [BIT_DEPTH-1:0]      wd_d;
  logic [NumRegs-1:0]        set_vec, clr_vec, busy_d;
  logic [CntW-1:0]           count_d;

  // Readiness depends only on registered occupancy, so a full FIFO stalls even while popping.
  assign mdu_ready  = !rst && (fifo_count < CntW'(FIFO_DEPTH));
  assign accept     = mdu_valid && mdu_ready;
  assign alu_req    = alu_we && (alu_addr != '0);
  assign fifo_empty = (fifo_count == '0);
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

`ifdef WB_MDU_BYPASS_EN
  assign bypass = accept && !alu_req && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = !alu_req && !fifo_empty;
  assign push = accept && !bypass;

  always_comb begin
    count_d = fifo_count;
    if (push && !pop) begin
      count_d = fifo_count + 1'b1;
    end else if (pop && !push) begin
      count_d = fifo_count - 1'b1;
    end
  end

  always_comb begin
    we_d    = 1'b0;
    addr3_d = addr3;
    wd_d    = wd;
    clr_vec = '0;
    if (alu_req) begin
      we_d    = 1'b1;
      addr3_d = alu_addr;
      wd_d    = alu_wd;
    end else if (pop) begin
      we_d    = (head_addr != '0);
      addr3_d = head_addr;
      wd_d    = head_data;
      clr_vec = NumRegs'(1) << head_addr;
    end else if (bypass) begin
      we_d    = (mdu_addr != '0);
      addr3_d = mdu_addr;
      wd_d    = mdu_wd;
      clr_vec = NumRegs'(1) << mdu_addr;
    end
  end

  // A new issue overrides a retiring write to the same register.
  always_comb begin
    set_vec   = issue_valid ? (NumRegs'(1) << issue_addr) : '0;
    busy_d    = (busy_vec & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we         <= 1'b0;
      addr3      <= '0;
      wd         <= '0;
      busy_vec   <= '0;
      fifo_count <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      we         <= we_d;
      addr3      <= addr3_d;
      wd         <= wd_d;
      busy_vec   <= busy_d;
      fifo_count <= count_d;
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= mdu_addr;
        fifo_data_q[wr_ptr_q] <= mdu_wd;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule
